// File: rtl/cla_carry_pipe_pkg.sv
// cla_pkg: shared width constants, stage payload type and the prefix combine operator
// for the pipelined carry-lookahead path.
package cla_pkg;
    localparam int WIDTH = 32;
    localparam int LOG2W = $clog2(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] p_orig;
        logic             cin;
    } stage_t;

    function automatic logic [1:0] pg_combine(input logic gh, input logic ph, input logic gl, input logic pl);
        return {gh | (ph & gl), ph & pl};
    endfunction
endpackage

// File: rtl/cla_carry_pipe_ks_level.sv
// ks_level: one combinational Kogge-Stone prefix level with a fixed span.
module ks_level
    import cla_pkg::*;
#(
    parameter int W    = 32,
    parameter int SPAN = 1
) (
    input  logic [W-1:0] g_i,
    input  logic [W-1:0] p_i,
    output logic [W-1:0] g_o,
    output logic [W-1:0] p_o
);
    for (genvar i = 0; i < W; i++) begin : g_bit
        if (i >= SPAN) begin : g_comb
            assign {g_o[i], p_o[i]} = pg_combine(g_i[i], p_i[i], g_i[i-SPAN], p_i[i-SPAN]);
        end else begin : g_pass
            assign g_o[i] = g_i[i];
            assign p_o[i] = p_i[i];
        end
    end
endmodule

// File: rtl/cla_carry_pipe.sv
// cla_carry_pipe: pipelined Kogge-Stone carry resolver producing sum, carry-out,
// signed overflow and zero flag behind a valid/ready handshake on both sides.
module cla_carry_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = cla_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] g,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int LVLS = $clog2(WIDTH);

    stage_t           stage_q [LVLS];
    stage_t           stage_d [LVLS];
    logic [WIDTH-1:0] lg      [LVLS];
    logic [WIDTH-1:0] lp      [LVLS];
    logic [LVLS-1:0]  valid_q;
    logic             out_valid_q, cout_q, ovf_q, zero_q;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH:0]   c;
    logic             advance, accept;

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance && !flush;
    assign accept   = in_valid && in_ready;

    for (genvar k = 0; k < LVLS; k++) begin : g_lvl
        ks_level #(.W(WIDTH), .SPAN(1 << k)) u_lvl (
            .g_i(stage_q[k].g),
            .p_i(stage_q[k].p),
            .g_o(lg[k]),
            .p_o(lp[k])
        );
    end

    // carry-in folded into bit 0 generate so the prefix tree yields c[i+1] = G[i:0] directly
    always_comb begin
        stage_d[0] = '{g: {g[WIDTH-1:1], g[0] | (p[0] & cin)}, p: p, p_orig: p, cin: cin};
        for (int k = 1; k < LVLS; k++)
            stage_d[k] = '{g: lg[k-1], p: lp[k-1], p_orig: stage_q[k-1].p_orig, cin: stage_q[k-1].cin};
    end

    assign c     = {lg[LVLS-1], stage_q[LVLS-1].cin};
    assign sum_d = stage_q[LVLS-1].p_orig ^ c[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q     <= '{default: '0};
            valid_q     <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (flush) begin
            valid_q     <= '0;
            out_valid_q <= 1'b0;
        end else if (advance) begin
            stage_q     <= stage_d;
            valid_q     <= {valid_q[LVLS-2:0], accept};
            out_valid_q <= valid_q[LVLS-1];
            sum_q       <= sum_d;
            cout_q      <= c[WIDTH];
            ovf_q       <= c[WIDTH] ^ c[WIDTH-1];
            zero_q      <= sum_d == '0;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_cla_carry_pipe.sv
// tb_cla_carry_pipe: scoreboard bench for the pipelined carry resolver; expected
// results come from a plain integer-add reference model.
module tb_cla_carry_pipe;
    logic        clk, rst_n, flush, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, zero;
    logic [31:0] p, g, sum;

    int          checks = 0;
    int          failures = 0;
    logic [34:0] exp_q[$];
    logic        stalled = 1'b0;
    logic [34:0] held = '0;

    cla_carry_pipe dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .p(p), .g(g), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {sum, cout, ovf, zero} of a + b + c
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic c);
        logic [32:0] full;
        logic [31:0] low;
        full = {1'b0, a} + {1'b0, b} + {32'd0, c};
        low  = {1'b0, a[30:0]} + {1'b0, b[30:0]} + {31'd0, c};
        return {full[31:0], full[32], full[32] ^ low[31], full[31:0] == 32'd0};
    endfunction

    // one clock: drive at edge+1, sample mid-cycle, score handshakes, then advance past the edge
    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b, input logic c,
                         input logic ordy, input logic fl, output logic acc, output logic got);
        logic [34:0] o, e;
        in_valid = v; p = a ^ b; g = a & b; cin = c; out_ready = ordy; flush = fl;
        #4;
        checks++;
        if (in_ready !== ((!out_valid || out_ready) && !flush)) begin
            failures++;
            $display("FAIL in_ready: got %b want %b (out_valid=%b out_ready=%b flush=%b)",
                     in_ready, (!out_valid || out_ready) && !flush, out_valid, out_ready, flush);
        end
        o = {sum, cout, ovf, zero};
        if (stalled) begin
            checks++;
            if (o !== held || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold: got %h valid=%b want %h valid=1", o, out_valid, held);
            end
        end
        acc = in_valid && in_ready;
        got = out_valid && out_ready && !flush;
        if (got) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output: got sum=%h with no op in flight", sum);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL result: got sum=%h cout=%b ovf=%b zero=%b want sum=%h cout=%b ovf=%b zero=%b",
                             sum, cout, ovf, zero, e[34:3], e[2], e[1], e[0]);
                end
            end
        end
        if (flush) exp_q.delete();
        else if (acc) exp_q.push_back(model(a, b, c));
        stalled = out_valid && !out_ready && !flush;
        held = o;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_result(output int lat);
        logic acc, got;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 12) begin
            cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, acc, got);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; p = '0; g = '0; cin = 1'b0;
        @(posedge clk);
        #2;
        checks++;
        if ({out_valid, sum, cout, ovf, zero} !== 36'd0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b ovf=%b zero=%b want all 0",
                     out_valid, sum, cout, ovf, zero);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_carry_chain();
        logic acc, got;
        int   lat;
        cycle(1'b1, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b1, 1'b0, acc, got);
        checks++;
        if (acc !== 1'b1) begin failures++; $display("FAIL chain_accept: got %b want 1", acc); end
        wait_result(lat);
        checks++;
        if (lat != 6) begin failures++; $display("FAIL chain_latency: got %0d want 6", lat); end
    endtask

    task automatic test_overflow_and_cin();
        logic acc, got;
        int   lat;
        cycle(1'b1, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b1, 1'b0, acc, got);
        wait_result(lat);
        cycle(1'b1, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1, 1'b0, acc, got);
        cycle(1'b1, 32'h0000000F, 32'h0, 1'b0, 1'b1, 1'b0, acc, got);
        wait_result(lat);
        wait_result(lat);
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL ovf_drain: got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic        acc, got, c_r;
        logic [31:0] a_r, b_r;
        int          sent = 0, rcv = 0, cyc = 0;
        a_r = $urandom; b_r = $urandom; c_r = 1'($urandom_range(0, 1));
        while ((sent < 20 || rcv < sent) && cyc < 400) begin
            cycle(sent < 20, a_r, b_r, c_r, (cyc % 3) == 0, 1'b0, acc, got);
            if (acc) begin
                sent++;
                a_r = $urandom; b_r = $urandom; c_r = 1'($urandom_range(0, 1));
            end
            if (got) rcv++;
            cyc++;
        end
        checks++;
        if (rcv != 20 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL backpressure_count: got %0d received %0d pending want 20 received 0 pending", rcv, exp_q.size());
        end
    endtask

    task automatic test_flush();
        logic acc, got;
        int   lat, seen = 0;
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h100 * i + 5, 32'h33, 1'b0, 1'b1, 1'b0, acc, got);
        cycle(1'b1, 32'hDEADBEEF, 32'h12345678, 1'b1, 1'b1, 1'b1, acc, got);
        checks++;
        if (acc !== 1'b0) begin failures++; $display("FAIL flush_accept: got %b want 0", acc); end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, acc, got);
            if (got) seen++;
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL flush_quiet: got %0d outputs want 0", seen); end
        cycle(1'b1, 32'h89ABCDEF, 32'h76543211, 1'b0, 1'b1, 1'b0, acc, got);
        wait_result(lat);
        checks++;
        if (lat != 6) begin failures++; $display("FAIL flush_latency: got %0d want 6", lat); end
    endtask

    task automatic test_async_reset();
        logic acc, got;
        int   n = 0, seen = 0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h1000 + i, 32'h2222, 1'b0, 1'b0, 1'b0, acc, got);
        while (!out_valid && n < 12) begin
            cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, acc, got);
            n++;
        end
        checks++;
        if (out_valid !== 1'b1 || sum === 32'd0) begin
            failures++;
            $display("FAIL pre_reset_stall: got valid=%b sum=%h want valid=1 sum nonzero", out_valid, sum);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if ({out_valid, sum, cout, ovf, zero} !== 36'd0) begin
            failures++;
            $display("FAIL async_reset: got valid=%b sum=%h cout=%b ovf=%b zero=%b want all 0",
                     out_valid, sum, cout, ovf, zero);
        end
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        stalled = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 15; i++) begin
            cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, acc, got);
            if (got) seen++;
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL stale_after_reset: got %0d outputs want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_carry_chain();
        test_overflow_and_cin();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
